rojoblaze_flow_ctrl: RTL and testbench

- Program-flow sequencer for the pipelined RojoBlaze.
- Owns the fetch PC, the 31-entry CALL/RETURN stack and the interrupt-enable/flag-preserve logic.
- Decodes the execute-stage instruction for JUMP/CALL/RETURN/RETURNI/INTERRUPT_SET and the external interrupt, then redirects fetch and flushes the wrong-path instruction.
- Sits between the execute stage, the ALU flag register and the instruction ROM address bus.

---
 rtl/rojoblaze_flow_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_rojoblaze_flow_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rojoblaze_flow_ctrl.sv
// Program-flow sequencer for the pipelined RojoBlaze: owns the fetch PC, the
// CALL/RETURN stack and the interrupt enable / flag-preserve state.
module rojoblaze_flow_ctrl #(
   parameter int                ADDR_W      = 10,
   parameter int                STACK_DEPTH = 31,
   parameter logic [ADDR_W-1:0] INT_VECTOR  = 10'h3FF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              stall,
   input  logic              ex_valid,
   input  logic [17:0]       ex_instr,
   input  logic [ADDR_W-1:0] ex_pc,
   input  logic              zero_flag,
   input  logic              carry_flag,
   input  logic              interrupt,
   output logic [ADDR_W-1:0] pc,
   output logic              flush,
   output logic              int_ack,
   output logic              int_enable,
   output logic              flag_restore,
   output logic              saved_z,
   output logic              saved_c,
   output logic              stack_overflow,
   output logic              stack_underflow
);

   localparam int SP_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam int CNT_W = $clog2(STACK_DEPTH + 1);
   localparam logic [SP_W-1:0]  SP_LAST  = SP_W'(STACK_DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STACK_DEPTH);

   localparam logic [5:0] OP_JUMP_U = 6'b110100;
   localparam logic [5:0] OP_JUMP_C = 6'b110101;
   localparam logic [5:0] OP_CALL_U = 6'b110000;
   localparam logic [5:0] OP_CALL_C = 6'b110001;
   localparam logic [5:0] OP_RET_U  = 6'b101010;
   localparam logic [5:0] OP_RET_C  = 6'b101011;
   localparam logic [5:0] OP_RETI   = 6'b111000;
   localparam logic [5:0] OP_INTSET = 6'b111100;

   logic [ADDR_W-1:0] r_pc;
   logic              r_flush;
   logic              r_int_ack;
   logic              r_int_enable;
   logic              r_flag_restore;
   logic              r_saved_z;
   logic              r_saved_c;
   logic              r_overflow;
   logic              r_underflow;
   logic [SP_W-1:0]   r_sp;
   logic [CNT_W-1:0]  r_count;
   logic [ADDR_W-1:0] r_stack [STACK_DEPTH];

   logic [5:0]        w_opcode;
   logic [1:0]        w_cond;
   logic [ADDR_W-1:0] w_target;
   logic              w_cond_true;
   logic              w_go;
   logic              w_jump;
   logic              w_call;
   logic              w_ret;
   logic              w_reti;
   logic              w_intset;
   logic              w_int_entry;
   logic              w_push;
   logic              w_pop;
   logic [ADDR_W-1:0] w_ret_addr;
   logic [ADDR_W-1:0] w_pc_inc;
   logic [SP_W-1:0]   w_sp_inc;
   logic [SP_W-1:0]   w_sp_dec;
   logic [ADDR_W-1:0] w_pop_data;
   logic [ADDR_W-1:0] w_next_pc;

   assign w_opcode   = ex_instr[17:12];
   assign w_cond     = ex_instr[11:10];
   assign w_target   = ex_instr[ADDR_W-1:0];
   assign w_go       = ex_valid & ~stall;
   assign w_ret_addr = ex_pc + ADDR_W'(1);
   assign w_pc_inc   = r_pc + ADDR_W'(1);
   assign w_sp_inc   = (r_sp == SP_LAST) ? SP_W'(0) : r_sp + SP_W'(1);
   assign w_sp_dec   = (r_sp == SP_W'(0)) ? SP_LAST : r_sp - SP_W'(1);
   assign w_pop_data = r_stack[w_sp_dec];

   // Branch condition against the current ALU flags
   always_comb begin
      w_cond_true = 1'b0;
      case (w_cond)
         2'b00:   w_cond_true = zero_flag;
         2'b01:   w_cond_true = ~zero_flag;
         2'b10:   w_cond_true = carry_flag;
         2'b11:   w_cond_true = ~carry_flag;
         default: w_cond_true = 1'b0;
      endcase
   end

   // Flow-control decode of the execute-stage instruction
   always_comb begin
      w_jump   = 1'b0;
      w_call   = 1'b0;
      w_ret    = 1'b0;
      w_reti   = 1'b0;
      w_intset = 1'b0;
      if (w_go) begin
         case (w_opcode)
            OP_JUMP_U: w_jump   = 1'b1;
            OP_JUMP_C: w_jump   = w_cond_true;
            OP_CALL_U: w_call   = 1'b1;
            OP_CALL_C: w_call   = w_cond_true;
            OP_RET_U:  w_ret    = 1'b1;
            OP_RET_C:  w_ret    = w_cond_true;
            OP_RETI:   w_reti   = 1'b1;
            OP_INTSET: w_intset = 1'b1;
            default:   w_jump   = 1'b0;
         endcase
      end else begin
         w_jump = 1'b0;
      end
   end

   // A taken redirect or an interrupt-control opcode defers the interrupt
   assign w_int_entry = w_go & interrupt & r_int_enable
                        & ~(w_jump | w_call | w_ret | w_reti | w_intset);
   assign w_push      = w_call | w_int_entry;
   assign w_pop       = w_ret | w_reti;

   // Next fetch address selection
   always_comb begin
      w_next_pc = w_pc_inc;
      if (w_jump || w_call) begin
         w_next_pc = w_target;
      end else if (w_pop) begin
         w_next_pc = w_pop_data;
      end else if (w_int_entry) begin
         w_next_pc = INT_VECTOR;
      end else begin
         w_next_pc = w_pc_inc;
      end
   end

   // PC, pulse outputs and interrupt state
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_pc           <= ADDR_W'(0);
         r_flush        <= 1'b0;
         r_int_ack      <= 1'b0;
         r_int_enable   <= 1'b0;
         r_flag_restore <= 1'b0;
         r_saved_z      <= 1'b0;
         r_saved_c      <= 1'b0;
      end else if (stall) begin
         r_flush        <= 1'b0;
         r_int_ack      <= 1'b0;
         r_flag_restore <= 1'b0;
      end else begin
         r_pc           <= w_next_pc;
         r_flush        <= w_jump | w_call | w_pop | w_int_entry;
         r_int_ack      <= w_int_entry;
         r_flag_restore <= w_reti;
         if (w_reti || w_intset) begin
            r_int_enable <= ex_instr[0];
         end else if (w_int_entry) begin
            r_int_enable <= 1'b0;
         end
         if (w_int_entry) begin
            r_saved_z <= zero_flag;
            r_saved_c <= carry_flag;
         end
      end
   end

   // Stack pointer, occupancy and sticky error flags
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_sp        <= SP_W'(0);
         r_count     <= CNT_W'(0);
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else if (w_push) begin
         r_sp <= w_sp_inc;
         if (r_count == CNT_FULL) begin
            r_overflow <= 1'b1;
         end else begin
            r_count <= r_count + CNT_W'(1);
         end
      end else if (w_pop) begin
         r_sp <= w_sp_dec;
         if (r_count == CNT_W'(0)) begin
            r_underflow <= 1'b1;
         end else begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

   // Stack storage; contents are left undefined by reset
   always_ff @(posedge clk) begin
      if (reset_n && w_push) begin
         r_stack[r_sp] <= w_ret_addr;
      end
   end

   assign pc              = r_pc;
   assign flush           = r_flush;
   assign int_ack         = r_int_ack;
   assign int_enable      = r_int_enable;
   assign flag_restore    = r_flag_restore;
   assign saved_z         = r_saved_z;
   assign saved_c         = r_saved_c;
   assign stack_overflow  = r_overflow;
   assign stack_underflow = r_underflow;

endmodule

// File: tb/tb_rojoblaze_flow_ctrl.sv
// Self-checking bench for rojoblaze_flow_ctrl: directed scenarios plus a
// randomized run against a queue-based behavioural model.
module tb_rojoblaze_flow_ctrl;

   localparam logic [5:0] J_U  = 6'b110100;
   localparam logic [5:0] J_C  = 6'b110101;
   localparam logic [5:0] C_U  = 6'b110000;
   localparam logic [5:0] C_C  = 6'b110001;
   localparam logic [5:0] R_U  = 6'b101010;
   localparam logic [5:0] R_C  = 6'b101011;
   localparam logic [5:0] RETI = 6'b111000;
   localparam logic [5:0] ISET = 6'b111100;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        stall = 1'b0;
   logic        ex_valid = 1'b0;
   logic [17:0] ex_instr = 18'h0;
   logic [9:0]  ex_pc = 10'h0;
   logic        zero_flag = 1'b0;
   logic        carry_flag = 1'b0;
   logic        interrupt = 1'b0;
   logic [9:0]  pc;
   logic        flush, int_ack, int_enable, flag_restore;
   logic        saved_z, saved_c, stack_overflow, stack_underflow;

   int n_cmp = 0;
   int n_err = 0;

   // Behavioural model state
   logic [9:0] m_pc = 10'h0;
   bit         m_pc_known = 1'b1;
   bit         m_flush, m_ack, m_ie, m_fr, m_sz, m_sc, m_ovf, m_unf;
   logic [9:0] m_stack[$];

   always #5 clk = ~clk;

   rojoblaze_flow_ctrl dut (
      .clk(clk), .reset_n(reset_n), .stall(stall), .ex_valid(ex_valid),
      .ex_instr(ex_instr), .ex_pc(ex_pc), .zero_flag(zero_flag),
      .carry_flag(carry_flag), .interrupt(interrupt), .pc(pc), .flush(flush),
      .int_ack(int_ack), .int_enable(int_enable), .flag_restore(flag_restore),
      .saved_z(saved_z), .saved_c(saved_c), .stack_overflow(stack_overflow),
      .stack_underflow(stack_underflow)
   );

   function automatic logic [17:0] mk(input logic [5:0] op, input logic [1:0] c, input logic [9:0] a);
      return {op, c, a};
   endfunction

   task automatic model_push(input logic [9:0] v);
      if (m_stack.size() == 31) begin
         m_ovf = 1'b1;
         m_stack.delete(0);
      end
      m_stack.push_back(v);
   endtask

   task automatic model_pop();
      if (m_stack.size() == 0) begin
         m_unf = 1'b1;
         m_pc_known = 1'b0;
      end else begin
         m_pc = m_stack.pop_back();
         m_pc_known = 1'b1;
      end
   endtask

   task automatic model_update();
      logic [5:0] op;
      logic [1:0] c;
      bit         ct;
      op = ex_instr[17:12];
      c  = ex_instr[11:10];
      ct = (c == 2'd0) ? zero_flag : (c == 2'd1) ? !zero_flag :
           (c == 2'd2) ? carry_flag : !carry_flag;
      if (!reset_n) begin
         m_pc = 10'h0; m_pc_known = 1'b1;
         m_flush = 1'b0; m_ack = 1'b0; m_ie = 1'b0; m_fr = 1'b0;
         m_sz = 1'b0; m_sc = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
         m_stack.delete();
      end else if (stall) begin
         m_flush = 1'b0; m_ack = 1'b0; m_fr = 1'b0;
      end else begin
         m_flush = 1'b0; m_ack = 1'b0; m_fr = 1'b0;
         if (ex_valid && (op == J_U || (op == J_C && ct))) begin
            m_pc = ex_instr[9:0]; m_pc_known = 1'b1; m_flush = 1'b1;
         end else if (ex_valid && (op == C_U || (op == C_C && ct))) begin
            model_push(ex_pc + 10'd1);
            m_pc = ex_instr[9:0]; m_pc_known = 1'b1; m_flush = 1'b1;
         end else if (ex_valid && (op == R_U || (op == R_C && ct))) begin
            model_pop(); m_flush = 1'b1;
         end else if (ex_valid && op == RETI) begin
            model_pop(); m_flush = 1'b1; m_fr = 1'b1; m_ie = ex_instr[0];
         end else if (ex_valid && op == ISET) begin
            m_ie = ex_instr[0]; m_pc = m_pc + 10'd1;
         end else if (ex_valid && interrupt && m_ie) begin
            model_push(ex_pc + 10'd1);
            m_pc = 10'h3FF; m_pc_known = 1'b1;
            m_sz = zero_flag; m_sc = carry_flag;
            m_ie = 1'b0; m_ack = 1'b1; m_flush = 1'b1;
         end else begin
            m_pc = m_pc + 10'd1;
         end
      end
   endtask

   task automatic cycle();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0; stall = 1'b0; ex_valid = 1'b0; interrupt = 1'b0;
      cycle();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; ex_valid = 1'b1; ex_instr = mk(J_U, 2'b00, 10'h155);
      cycle();
      cycle();
      n_cmp++;
      if ({pc, flush, int_ack, int_enable, flag_restore, saved_z, saved_c,
           stack_overflow, stack_underflow} !== 18'h0) begin
         n_err++;
         $display("FAIL reset_state: got pc=%h flags=%b want all zero", pc,
                  {flush, int_ack, int_enable, flag_restore, saved_z, saved_c, stack_overflow, stack_underflow});
      end
      reset_n = 1'b1; ex_valid = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         cycle();
         n_cmp++;
         if (pc !== 10'(i) || flush !== 1'b0) begin
            n_err++;
            $display("FAIL bubble_pc[%0d]: got pc=%h flush=%b want pc=%h flush=0", i, pc, flush, 10'(i));
         end
      end
   endtask

   task automatic test_call_return();
      ex_valid = 1'b1; ex_pc = 10'h010; ex_instr = mk(C_U, 2'b00, 10'h200);
      cycle();
      n_cmp++;
      if (pc !== 10'h200 || flush !== 1'b1) begin
         n_err++; $display("FAIL call: got pc=%h flush=%b want 200/1", pc, flush);
      end
      ex_pc = 10'h200; ex_instr = mk(R_U, 2'b00, 10'h000);
      cycle();
      n_cmp++;
      if (pc !== 10'h011 || flush !== 1'b1) begin
         n_err++; $display("FAIL return: got pc=%h flush=%b want 011/1", pc, flush);
      end
   endtask

   task automatic test_cond_jump();
      ex_pc = 10'h011; ex_instr = mk(J_C, 2'b01, 10'h080); zero_flag = 1'b1;
      cycle();
      n_cmp++;
      if (pc !== 10'h012 || flush !== 1'b0) begin
         n_err++; $display("FAIL jnz_not_taken: got pc=%h flush=%b want 012/0", pc, flush);
      end
      zero_flag = 1'b0;
      cycle();
      n_cmp++;
      if (pc !== 10'h080 || flush !== 1'b1) begin
         n_err++; $display("FAIL jnz_taken: got pc=%h flush=%b want 080/1", pc, flush);
      end
   endtask

   task automatic test_interrupt();
      ex_pc = 10'h080; ex_instr = mk(ISET, 2'b00, 10'h001); interrupt = 1'b1;
      cycle();
      n_cmp++;
      if (int_enable !== 1'b1 || flush !== 1'b0 || int_ack !== 1'b0 || pc !== 10'h081) begin
         n_err++; $display("FAIL int_set: got ie=%b flush=%b ack=%b pc=%h want 1/0/0/081", int_enable, flush, int_ack, pc);
      end
      ex_pc = 10'h123; ex_instr = 18'h0; zero_flag = 1'b1; carry_flag = 1'b0;
      cycle();
      n_cmp++;
      if ({pc, int_ack, int_enable, saved_z, saved_c, flush} !== {10'h3FF, 5'b10101}) begin
         n_err++; $display("FAIL int_entry: got pc=%h ack=%b ie=%b sz=%b sc=%b flush=%b want 3ff/1/0/1/0/1",
                           pc, int_ack, int_enable, saved_z, saved_c, flush);
      end
      interrupt = 1'b0; ex_pc = 10'h3FF; ex_instr = mk(RETI, 2'b00, 10'h001);
      cycle();
      n_cmp++;
      if (pc !== 10'h124 || flag_restore !== 1'b1 || int_enable !== 1'b1 || int_ack !== 1'b0) begin
         n_err++; $display("FAIL returni: got pc=%h fr=%b ie=%b ack=%b want 124/1/1/0", pc, flag_restore, int_enable, int_ack);
      end
      // taken jump beats a pending interrupt; it is taken on the next valid cycle
      interrupt = 1'b1; ex_pc = 10'h124; ex_instr = mk(J_U, 2'b00, 10'h055);
      cycle();
      n_cmp++;
      if (pc !== 10'h055 || int_ack !== 1'b0 || int_enable !== 1'b1 || flag_restore !== 1'b0) begin
         n_err++; $display("FAIL jump_beats_int: got pc=%h ack=%b ie=%b fr=%b want 055/0/1/0", pc, int_ack, int_enable, flag_restore);
      end
      ex_valid = 1'b0;
      cycle();
      n_cmp++;
      if (pc !== 10'h056 || int_ack !== 1'b0) begin
         n_err++; $display("FAIL int_bubble: got pc=%h ack=%b want 056/0", pc, int_ack);
      end
      ex_valid = 1'b1; ex_pc = 10'h056; ex_instr = 18'h0; zero_flag = 1'b0; carry_flag = 1'b1;
      cycle();
      n_cmp++;
      if (pc !== 10'h3FF || int_ack !== 1'b1 || saved_z !== 1'b0 || saved_c !== 1'b1) begin
         n_err++; $display("FAIL int_retry: got pc=%h ack=%b sz=%b sc=%b want 3ff/1/0/1", pc, int_ack, saved_z, saved_c);
      end
      interrupt = 1'b0;
   endtask

   task automatic test_stack_limits();
      do_reset();
      ex_valid = 1'b1;
      for (int i = 0; i < 32; i++) begin
         ex_pc = 10'(i * 4); ex_instr = mk(C_U, 2'b00, 10'($urandom_range(0, 1023)));
         cycle();
         if (i >= 30) begin
            n_cmp++;
            if (stack_overflow !== ((i == 31) ? 1'b1 : 1'b0)) begin
               n_err++; $display("FAIL overflow_after_call%0d: got %b want %b", i + 1, stack_overflow, (i == 31));
            end
         end
      end
      for (int k = 0; k < 31; k++) begin
         ex_instr = mk(R_U, 2'b00, 10'h000);
         cycle();
         n_cmp++;
         if (pc !== 10'((31 - k) * 4 + 1)) begin
            n_err++; $display("FAIL ret_pop%0d: got pc=%h want %h", k, pc, 10'((31 - k) * 4 + 1));
         end
      end
      n_cmp++;
      if (stack_underflow !== 1'b0) begin
         n_err++; $display("FAIL underflow_early: got %b want 0", stack_underflow);
      end
      cycle();
      n_cmp++;
      if (stack_underflow !== 1'b1 || stack_overflow !== 1'b1 || flush !== 1'b1) begin
         n_err++; $display("FAIL underflow: got unf=%b ovf=%b flush=%b want 1/1/1", stack_underflow, stack_overflow, flush);
      end
   endtask

   task automatic test_stall();
      do_reset();
      ex_valid = 1'b1; ex_pc = 10'h040; ex_instr = mk(C_U, 2'b00, 10'h100);
      cycle();
      stall = 1'b1; ex_pc = 10'h100; ex_instr = mk(J_U, 2'b00, 10'h2AA);
      for (int i = 0; i < 3; i++) begin
         cycle();
         n_cmp++;
         if (pc !== 10'h100 || flush !== 1'b0) begin
            n_err++; $display("FAIL stall_hold%0d: got pc=%h flush=%b want 100/0", i, pc, flush);
         end
      end
      stall = 1'b0;
      cycle();
      n_cmp++;
      if (pc !== 10'h2AA || flush !== 1'b1) begin
         n_err++; $display("FAIL stall_release: got pc=%h flush=%b want 2aa/1", pc, flush);
      end
      ex_pc = 10'h2AA; ex_instr = mk(R_U, 2'b00, 10'h000);
      cycle();
      n_cmp++;
      if (pc !== 10'h041) begin
         n_err++; $display("FAIL stall_stack: got pc=%h want 041", pc);
      end
   endtask

   task automatic test_reset_mid_redirect();
      reset_n = 1'b0; ex_valid = 1'b1; ex_instr = mk(J_U, 2'b00, 10'h155);
      cycle();
      n_cmp++;
      if (pc !== 10'h000 || flush !== 1'b0) begin
         n_err++; $display("FAIL reset_redirect: got pc=%h flush=%b want 000/0", pc, flush);
      end
      reset_n = 1'b1; ex_valid = 1'b0;
      cycle();
      n_cmp++;
      if (pc !== 10'h001 || flush !== 1'b0) begin
         n_err++; $display("FAIL reset_after: got pc=%h flush=%b want 001/0", pc, flush);
      end
   endtask

   task automatic test_random();
      logic [5:0] ops [9];
      logic [7:0] got_f, exp_f;
      ops = '{J_U, J_C, C_U, C_C, R_U, R_C, RETI, ISET, 6'h00};
      for (int n = 0; n < 1500; n++) begin
         reset_n    = ($urandom_range(0, 199) != 0);
         stall      = ($urandom_range(0, 9) < 2);
         ex_valid   = ($urandom_range(0, 9) < 8);
         interrupt  = ($urandom_range(0, 9) < 3);
         zero_flag  = 1'($urandom_range(0, 1));
         carry_flag = 1'($urandom_range(0, 1));
         ex_pc      = 10'($urandom_range(0, 1023));
         ex_instr   = mk(ops[$urandom_range(0, 8)], 2'($urandom_range(0, 3)), 10'($urandom_range(0, 1023)));
         if ($urandom_range(0, 9) == 0) ex_instr[17:12] = 6'($urandom_range(0, 63));
         cycle();
         got_f = {flush, int_ack, int_enable, flag_restore, saved_z, saved_c, stack_overflow, stack_underflow};
         exp_f = {m_flush, m_ack, m_ie, m_fr, m_sz, m_sc, m_ovf, m_unf};
         n_cmp++;
         if (got_f !== exp_f || (m_pc_known && pc !== m_pc)) begin
            n_err++;
            $display("FAIL random[%0d]: got pc=%h flags=%b want pc=%h(known=%0d) flags=%b",
                     n, pc, got_f, m_pc, m_pc_known, exp_f);
         end
      end
   endtask

   initial begin
      test_reset();
      test_call_return();
      test_cond_jump();
      test_interrupt();
      test_stack_limits();
      test_stall();
      test_reset_mid_redirect();
      do_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
